// File: rtl/video_dma_engine_if.sv
// Bus bundle for video_dma_engine: descriptor channels, memory read request,
// read data return, video memory write port and status.
//
// Handshakes (desc_valid/desc_ready, req_valid/req_ready): a transfer happens
// on a rising clk edge where both valid and ready are high. Once valid is
// raised, the payload stays stable and valid stays high until that edge.
// rd_valid carries no back-pressure: each cycle it is high delivers one beat.
interface video_dma_engine_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int VIDEOMEM_AW = 18,
  parameter int SRC_AW      = 16,
  parameter int LEN_W       = 16,
  parameter int NUM_CH      = 2,
  parameter int MAX_BURST   = 8
);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic [NUM_CH-1:0]             desc_valid;
  logic [NUM_CH-1:0]             desc_ready;
  logic [NUM_CH*SRC_AW-1:0]      desc_src;
  logic [NUM_CH*VIDEOMEM_AW-1:0] desc_dst;
  logic [NUM_CH*LEN_W-1:0]       desc_len;

  logic                          req_valid;
  logic                          req_ready;
  logic [SRC_AW-1:0]             req_addr;
  logic [BURST_W-1:0]            req_len;

  logic                          rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;

  logic                          vm_we;
  logic [VIDEOMEM_AW-1:0]        vm_addr;
  logic [DATA_WIDTH-1:0]         vm_wdata;

  logic [NUM_CH-1:0]             done;
  logic                          busy;

  // DMA engine side
  modport master (
    input  desc_valid, desc_src, desc_dst, desc_len,
    input  req_ready, rd_valid, rd_data,
    output desc_ready, req_valid, req_addr, req_len,
    output vm_we, vm_addr, vm_wdata, done, busy
  );

  // CPU / memory / video BRAM side
  modport slave (
    output desc_valid, desc_src, desc_dst, desc_len,
    output req_ready, rd_valid, rd_data,
    input  desc_ready, req_valid, req_addr, req_len,
    input  vm_we, vm_addr, vm_wdata, done, busy
  );
endinterface

// File: rtl/video_dma_engine.sv
// Multi-channel video DMA engine. Accepts (src, dst, len) descriptors on
// NUM_CH channels with round-robin arbitration, splits each transfer into
// read bursts of at most MAX_BURST beats, and writes every returned beat to
// video memory at an incrementing, wrapping destination address.
module video_dma_engine #(
  parameter int DATA_WIDTH  = 64,
  parameter int VIDEOMEM_AW = 18,
  parameter int SRC_AW      = 16,
  parameter int LEN_W       = 16,
  parameter int NUM_CH      = 2,
  parameter int MAX_BURST   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  video_dma_engine_if.master    bus,
  output logic [1:0]            o_dbg_state
);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CH_W-1:0]        r_last_grant;
  logic [CH_W-1:0]        r_ch;
  logic [SRC_AW-1:0]      r_cur_src;
  logic [VIDEOMEM_AW-1:0] r_cur_dst;
  logic [LEN_W-1:0]       r_remaining;
  logic [BURST_W-1:0]     r_beat_cnt;
  logic                   r_vm_we;
  logic [VIDEOMEM_AW-1:0] r_vm_addr;
  logic [DATA_WIDTH-1:0]  r_vm_wdata;

  logic [CH_W-1:0]        w_grant;
  logic                   w_grant_vld;
  logic [SRC_AW-1:0]      w_src;
  logic [VIDEOMEM_AW-1:0] w_dst;
  logic [LEN_W-1:0]       w_len;
  logic [BURST_W-1:0]     w_burst;

  // Channel k steps after 'last', wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] last, input int k);
    return CH_W'((int'(last) + k) % NUM_CH);
  endfunction

  // Round-robin pick: scan from farthest to nearest so the first requester
  // after last_grant is the one left standing.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (bus.desc_valid[next_idx(r_last_grant, k)]) begin
        w_grant     = next_idx(r_last_grant, k);
        w_grant_vld = 1'b1;
      end
    end
  end

  // Descriptor fields of the granted channel.
  always_comb begin
    w_src = bus.desc_src[int'(w_grant)*SRC_AW +: SRC_AW];
    w_dst = bus.desc_dst[int'(w_grant)*VIDEOMEM_AW +: VIDEOMEM_AW];
    w_len = bus.desc_len[int'(w_grant)*LEN_W +: LEN_W];
  end

  // Next burst size: min(remaining, MAX_BURST).
  always_comb begin
    w_burst = (r_remaining > LEN_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                : BURST_W'(r_remaining);
  end

  // Output decode from registered state; desc_ready is the only path that
  // looks at inputs, so a grant is acknowledged in the cycle it is offered.
  always_comb begin
    bus.desc_ready = '0;
    if (r_state == S_IDLE && w_grant_vld) begin
      bus.desc_ready = NUM_CH'(1) << w_grant;
    end
    bus.req_valid = (r_state == S_REQ);
    bus.req_addr  = (r_state == S_REQ) ? r_cur_src : '0;
    bus.req_len   = (r_state == S_REQ) ? w_burst : '0;
    bus.done      = (r_state == S_DONE) ? (NUM_CH'(1) << r_ch) : '0;
    bus.busy      = (r_state != S_IDLE);
    bus.vm_we     = r_vm_we;
    bus.vm_addr   = r_vm_addr;
    bus.vm_wdata  = r_vm_wdata;
    o_dbg_state   = r_state;
  end

  // Transfer FSM: accept descriptor, issue bursts, write beats, signal done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_ch         <= '0;
      r_cur_src    <= '0;
      r_cur_dst    <= '0;
      r_remaining  <= '0;
      r_beat_cnt   <= '0;
      r_vm_we      <= 1'b0;
      r_vm_addr    <= '0;
      r_vm_wdata   <= '0;
    end else begin
      r_vm_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_cur_src    <= w_src;
            r_cur_dst    <= w_dst;
            r_remaining  <= w_len;
            r_ch         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= (w_len != '0) ? S_REQ : S_DONE;
          end
        end
        S_REQ: begin
          if (bus.req_ready) begin
            r_beat_cnt <= w_burst;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.rd_valid) begin
            r_vm_we     <= 1'b1;
            r_vm_addr   <= r_cur_dst;
            r_vm_wdata  <= bus.rd_data;
            r_cur_dst   <= r_cur_dst + VIDEOMEM_AW'(1);
            r_cur_src   <= r_cur_src + SRC_AW'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            r_beat_cnt  <= r_beat_cnt - BURST_W'(1);
            if (r_beat_cnt == BURST_W'(1)) begin
              r_state <= (r_remaining == LEN_W'(1)) ? S_DONE : S_REQ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_video_dma_engine.sv
// Directed bench for video_dma_engine: memory responder, write monitor,
// expected-write scoreboard and a linear sequence of descriptor scenarios.
module tb_video_dma_engine;
  localparam int DW  = 64;
  localparam int VAW = 18;
  localparam int SAW = 16;
  localparam int LW  = 16;
  localparam int NCH = 2;
  localparam int MB  = 8;
  localparam int BW  = $clog2(MB + 1);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  video_dma_engine_if #(.DATA_WIDTH(DW), .VIDEOMEM_AW(VAW), .SRC_AW(SAW),
                        .LEN_W(LW), .NUM_CH(NCH), .MAX_BURST(MB)) bus ();

  video_dma_engine #(.DATA_WIDTH(DW), .VIDEOMEM_AW(VAW), .SRC_AW(SAW),
                     .LEN_W(LW), .NUM_CH(NCH), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .o_dbg_state(dbg_state)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  // scoreboard storage
  logic [VAW-1:0] wr_addr_q[$];
  logic [DW-1:0]  wr_data_q[$];
  logic [VAW-1:0] exp_addr_q[$];
  logic [DW-1:0]  exp_q[$];
  logic [SAW-1:0] rq_addr_q[$];
  logic [BW-1:0]  rq_len_q[$];
  int             done_cnt = 0;

  // responder configuration
  int cfg_stall   = 0;
  int cfg_gap_max = 0;
  bit cfg_spur    = 1'b0;

  function automatic logic [DW-1:0] data_of(input logic [SAW-1:0] a);
    return {16'hDA7A, a, 16'h5A5A, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // write / done monitor
  always @(negedge clk) begin
    if (rst_n && bus.vm_we) begin
      wr_addr_q.push_back(bus.vm_addr);
      wr_data_q.push_back(bus.vm_wdata);
    end
    if (rst_n && bus.done != '0) done_cnt++;
  end

  // memory model: accepts requests (optionally stalled), returns beats
  // (optionally with gaps), and optionally injects stray rd_valid.
  task automatic responder();
    int             resp_left = 0;
    int             gap       = 0;
    int             stall_left = 0;
    bit             in_stall  = 1'b0;
    logic [SAW-1:0] resp_addr = '0;
    logic [SAW-1:0] hold_addr = '0;
    logic [BW-1:0]  hold_len  = '0;
    forever begin
      @(negedge clk);
      bus.rd_valid  = 1'b0;
      bus.rd_data   = '0;
      bus.req_ready = 1'b0;
      if (!rst_n) begin
        resp_left = 0;
        gap       = 0;
        in_stall  = 1'b0;
      end else begin
        if (resp_left > 0) begin
          if (gap > 0) begin
            gap--;
          end else begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = data_of(resp_addr);
            resp_addr++;
            resp_left--;
            gap = (cfg_gap_max > 0) ? int'($urandom_range(cfg_gap_max, 0)) : 0;
          end
        end else if (cfg_spur && ($urandom_range(1, 0) == 1)) begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        if (bus.req_valid) begin
          if (!in_stall) begin
            in_stall   = 1'b1;
            stall_left = cfg_stall;
            hold_addr  = bus.req_addr;
            hold_len   = bus.req_len;
          end else begin
            check("req_addr_stable", 64'(bus.req_addr), 64'(hold_addr));
            check("req_len_stable", 64'(bus.req_len), 64'(hold_len));
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            bus.req_ready = 1'b1;
            resp_left     = int'(bus.req_len);
            resp_addr     = bus.req_addr;
            rq_addr_q.push_back(bus.req_addr);
            rq_len_q.push_back(bus.req_len);
            in_stall      = 1'b0;
          end
        end
      end
    end
  endtask

  // driver: offer one descriptor on a channel until it is accepted
  task automatic submit(input int ch, input logic [SAW-1:0] src,
                        input logic [VAW-1:0] dst, input logic [LW-1:0] len);
    bit got = 1'b0;
    bus.desc_src[ch*SAW +: SAW] = src;
    bus.desc_dst[ch*VAW +: VAW] = dst;
    bus.desc_len[ch*LW +: LW]   = len;
    bus.desc_valid[ch]          = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (bus.desc_ready[ch]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("desc_accepted", 64'(got), 64'd1);
    if (got) check("desc_ready_onehot", 64'(bus.desc_ready), 64'(1) << ch);
    tick();
    bus.desc_valid[ch] = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", 64'(ok), 64'd1);
    if (ok) check("done_channel", 64'(bus.done), 64'(1) << ch);
  endtask

  task automatic clear_sb();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_addr_q.delete();
    exp_q.delete();
    rq_addr_q.delete();
    rq_len_q.delete();
  endtask

  task automatic expect_writes(input logic [SAW-1:0] src, input logic [VAW-1:0] dst, input int len);
    logic [SAW-1:0] s;
    logic [VAW-1:0] d;
    s = src;
    d = dst;
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(d);
      exp_q.push_back(data_of(s));
      s = s + SAW'(1);
      d = d + VAW'(1);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, 64'(wr_addr_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_addr_q.size() > 0) begin
      check({tag, "_vm_addr"}, 64'(wr_addr_q.pop_front()), 64'(exp_addr_q.pop_front()));
      check({tag, "_vm_wdata"}, wr_data_q.pop_front(), exp_q.pop_front());
    end
  endtask

  // directed sequence
  initial begin
    logic [VAW-1:0] wrap_addr[4];
    int             done_before;

    bus.desc_valid = '0;
    bus.desc_src   = '0;
    bus.desc_dst   = '0;
    bus.desc_len   = '0;
    bus.req_ready  = 1'b0;
    bus.rd_valid   = 1'b0;
    bus.rd_data    = '0;
    fork
      responder();
    join_none

    // reset state
    #3;
    check("rst_desc_ready", 64'(bus.desc_ready), 64'd0);
    check("rst_req_valid", 64'(bus.req_valid), 64'd0);
    check("rst_req_addr", 64'(bus.req_addr), 64'd0);
    check("rst_req_len", 64'(bus.req_len), 64'd0);
    check("rst_vm_we", 64'(bus.vm_we), 64'd0);
    check("rst_vm_addr", 64'(bus.vm_addr), 64'd0);
    check("rst_vm_wdata", bus.vm_wdata, 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: ch0, 20 beats split 8/8/4
    clear_sb();
    submit(0, 16'h0100, 18'h00010, 16'd20);
    check("t1_req_valid_after_accept", 64'(bus.req_valid), 64'd1);
    check("t1_req_addr_first", 64'(bus.req_addr), 64'h0100);
    check("t1_req_len_first", 64'(bus.req_len), 64'd8);
    check("t1_busy", 64'(bus.busy), 64'd1);
    wait_done(0, 200);
    check("t1_last_we_with_done", 64'(bus.vm_we), 64'd1);
    check("t1_last_addr", 64'(bus.vm_addr), 64'h00023);
    tick();
    check("t1_done_one_cycle", 64'(bus.done), 64'd0);
    check("t1_idle_busy", 64'(bus.busy), 64'd0);
    check("t1_req_count", 64'(rq_addr_q.size()), 64'd3);
    if (rq_addr_q.size() == 3) begin
      check("t1_req0_addr", 64'(rq_addr_q[0]), 64'h0100);
      check("t1_req0_len", 64'(rq_len_q[0]), 64'd8);
      check("t1_req1_addr", 64'(rq_addr_q[1]), 64'h0108);
      check("t1_req1_len", 64'(rq_len_q[1]), 64'd8);
      check("t1_req2_addr", 64'(rq_addr_q[2]), 64'h0110);
      check("t1_req2_len", 64'(rq_len_q[2]), 64'd4);
    end
    expect_writes(16'h0100, 18'h00010, 20);
    compare_writes("t1");

    // 2: ch1 zero-length descriptor
    clear_sb();
    submit(1, 16'h0000, 18'h00000, 16'd0);
    check("t2_done_next_cycle", 64'(bus.done), 64'b10);
    check("t2_no_req", 64'(bus.req_valid), 64'd0);
    check("t2_no_we", 64'(bus.vm_we), 64'd0);
    tick();
    check("t2_done_one_cycle", 64'(bus.done), 64'd0);
    tick();
    tick();
    check("t2_req_count", 64'(rq_addr_q.size()), 64'd0);
    compare_writes("t2");

    // 3: both channels held valid, grants alternate from channel 0 after reset
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_sb();
    bus.desc_src   = {16'h0300, 16'h0200};
    bus.desc_dst   = {18'h00200, 18'h00100};
    bus.desc_len   = {16'd3, 16'd3};
    bus.desc_valid = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (bus.desc_ready != '0) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("t3_grant_seen", 64'(seen), 64'd1);
      check("t3_grant_channel", 64'(bus.desc_ready), 64'(1) << (g % 2));
      if (g % 2 == 0) expect_writes(16'h0200, 18'h00100, 3);
      else            expect_writes(16'h0300, 18'h00200, 3);
      tick();
      wait_done(g % 2, 100);
    end
    bus.desc_valid = 2'b00;
    tick();
    tick();
    compare_writes("t3");

    // 4: destination wraps at 2^18
    clear_sb();
    submit(0, 16'h0040, 18'h3FFFE, 16'd4);
    wait_done(0, 100);
    tick();
    wrap_addr = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    check("t4_write_count", 64'(wr_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size()) check("t4_wrap_addr", 64'(wr_addr_q[i]), 64'(wrap_addr[i]));
    end
    clear_sb();

    // 5: stalled requests, gapped data, stray rd_valid outside DATA
    cfg_stall   = 5;
    cfg_gap_max = 4;
    cfg_spur    = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    clear_sb();
    submit(1, 16'h0500, 18'h01000, 16'd10);
    wait_done(1, 600);
    check("t5_last_addr", 64'(bus.vm_addr), 64'h01009);
    for (int i = 0; i < 8; i++) tick();
    cfg_spur    = 1'b0;
    cfg_stall   = 0;
    cfg_gap_max = 0;
    tick();
    check("t5_req_count", 64'(rq_addr_q.size()), 64'd2);
    expect_writes(16'h0500, 18'h01000, 10);
    compare_writes("t5");

    // 6: asynchronous reset during beat 3 of 8, then a clean transfer
    clear_sb();
    submit(0, 16'h0600, 18'h02000, 16'd8);
    for (int i = 0; i < 100 && wr_addr_q.size() < 3; i++) tick();
    check("t6_reached_beat3", 64'(wr_addr_q.size()), 64'd3);
    done_before = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_req_valid", 64'(bus.req_valid), 64'd0);
    check("t6_async_req_addr", 64'(bus.req_addr), 64'd0);
    check("t6_async_req_len", 64'(bus.req_len), 64'd0);
    check("t6_async_vm_we", 64'(bus.vm_we), 64'd0);
    check("t6_async_vm_addr", 64'(bus.vm_addr), 64'd0);
    check("t6_async_vm_wdata", bus.vm_wdata, 64'd0);
    check("t6_async_done", 64'(bus.done), 64'd0);
    check("t6_async_busy", 64'(bus.busy), 64'd0);
    check("t6_async_desc_ready", 64'(bus.desc_ready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t6_no_done_after_abort", 64'(done_cnt), 64'(done_before));
    check("t6_idle_after_abort", 64'(bus.busy), 64'd0);
    clear_sb();
    submit(1, 16'h0700, 18'h03000, 16'd5);
    wait_done(1, 100);
    check("t6_last_we_with_done", 64'(bus.vm_we), 64'd1);
    tick();
    expect_writes(16'h0700, 18'h03000, 5);
    compare_writes("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/video_dma_engine.md
# video_dma_engine

Parametrised multi-channel DMA engine that moves frame data from system memory into video memory. It accepts transfer descriptors (source, destination, length) on NUM_CH independent channels and arbitrates them round-robin. Each transfer is split into memory read bursts of at most MAX_BURST beats, and every returned beat is written into video memory at an incrementing, wrapping address. It sits between the CPU-side descriptor registers and the video BRAM, generalising the single-channel, single-beat fetch controller.

## Interface
- DATA_WIDTH, 64, beat width (bits) of read data and video memory write data
- VIDEOMEM_AW, 18, video memory beat-address width
- SRC_AW, 16, source beat-address width
- LEN_W, 16, descriptor length width (beats)
- NUM_CH, 2, descriptor channels (≥1)
- MAX_BURST, 8, max beats per read request (≥1); BURST_W = $clog2(MAX_BURST+1)

Ports:
- clk  in  1  bus clock
- rst_n  in  1  reset, asynchronous, active-low
- desc_valid  in  NUM_CH  per-channel descriptor offered
- desc_ready  out  NUM_CH  per-channel descriptor accepted (one-hot or zero)
- desc_src  in  NUM_CH*SRC_AW  packed source addresses, channel i at [i*SRC_AW +: SRC_AW]
- desc_dst  in  NUM_CH*VIDEOMEM_AW  packed destination addresses
- desc_len  in  NUM_CH*LEN_W  packed lengths in beats
- req_valid  out  1  memory read request valid
- req_ready  in  1  memory accepts request
- req_addr  out  SRC_AW  burst start address
- req_len  out  BURST_W  burst beat count (1..MAX_BURST)
- rd_valid  in  1  read data beat valid
- rd_data  in  DATA_WIDTH  read data beat
- vm_we  out  1  video memory write enable (registered)
- vm_addr  out  VIDEOMEM_AW  video memory write address (registered)
- vm_wdata  out  DATA_WIDTH  video memory write data (registered)
- done  out  NUM_CH  one-cycle completion pulse for the finished channel
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, REQ, DATA, DONE.
- IDLE: if any desc_valid, grant = first requesting channel after last_grant, searching upward with wrap. desc_ready[grant]=1 combinationally in the same cycle. On handshake, latch src, dst, len, and ch, and set last_grant=grant. Next state is REQ if len≠0, else DONE.
- REQ: req_valid=1, req_addr=cur_src, req_len=min(remaining, MAX_BURST); both stay stable until req_ready. On req_ready, load beat_cnt=req_len and go to DATA.
- DATA: on each rd_valid, register vm_we=1, vm_addr=cur_dst, and vm_wdata=rd_data. Then cur_dst+=1 (mod 2^VIDEOMEM_AW), cur_src+=1 (mod 2^SRC_AW), remaining-=1, beat_cnt-=1. On the final beat of a burst: DONE if remaining reaches 0, else REQ.
- DONE: done[ch]=1 for exactly one cycle; go to IDLE.
- rd_valid outside DATA is ignored: no write, no counter change.
- No new descriptor is accepted until the current one reaches IDLE. desc_ready is 0 in all other states.
- Channels are independent only at descriptor granularity; bursts of different descriptors never interleave.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=NUM_CH-1 (channel 0 wins first), all counters 0. desc_ready, req_valid, req_addr, req_len, vm_we, vm_addr, vm_wdata, done, and busy are all 0.
- Acceptance to req_valid: 1 cycle.
- rd_valid to vm_we: 1 cycle. The last beat's write coincides with the DONE cycle, so done[ch] and the final vm_we are high together.
- Zero-length descriptor: accept, then done pulse the next cycle; no request, no write.
- Back-to-back bursts: after the last beat of a burst, req_valid is high the next cycle.
- rd_valid may have gaps of any length; req_ready may stall indefinitely.
- Minimum idle gap between descriptors: one IDLE cycle after DONE.
- Reset mid-transfer aborts immediately. No done pulse; any pending write is dropped.

## Test plan
- Ch0 desc src=0x0100, dst=0x00010, len=20, MAX_BURST=8, req_ready always 1 -> requests (0x0100,8), (0x0108,8), (0x0110,4); 20 writes at dst 0x10..0x23 with matching data; done[0] pulses with the last vm_we.
- Ch1 len=0 -> desc_ready[1] pulses, done[1] the next cycle, req_valid never asserted, vm_we never asserted.
- Both channels hold desc_valid with len=3, re-offering after each done -> grants alternate 0,1,0,1 starting with 0 after reset.
- dst=0x3FFFE, len=4 -> vm_addr sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- req_ready held low 5 cycles, rd_valid with random gaps, plus spurious rd_valid in IDLE -> req fields stable while stalled, only in-DATA beats written, write count equals len.
- rst_n low during beat 3 of 8 -> all outputs 0 asynchronously, no done. A new descriptor after release completes normally.
